// File: rtl/dsd_master_mc.sv
// Multi-channel DSD serializer: derives the DSD bit clock from mck, pulls one
// 16-bit word per channel per request, validates DoP markers, stops on silence.
module dsd_master_mc #(
  parameter int CHANNELS  = 2,
  parameter int LOCK_CNT  = 4,
  parameter int DOP_CHECK = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_n,
  input  logic                     stop_n,
  input  logic [1:0]               rate_sel,
  input  logic [16*CHANNELS-1:0]   data_in,
  input  logic [7:0]               marker_in,
  output logic                     data_req_out,
  output logic [CHANNELS-1:0]      sd_out,
  output logic                     sck_out,
  output logic                     dop_lock_out,
  output logic                     marker_err_out
);

  localparam int DATA_W = 16;
  localparam int WORD_W = DATA_W * CHANNELS;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRIME   = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_SILENCE = 2'd3;

  localparam logic [7:0] MARK_A = 8'h05;
  localparam logic [7:0] MARK_B = 8'hFA;

  localparam logic [WORD_W-1:0] SILENCE_WORD = {CHANNELS{16'h6969}};

  logic [1:0]        state;
  logic [1:0]        prime_cnt;
  logic [2:0]        d_half;
  logic [2:0]        ph;
  logic [3:0]        bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] shifted;
  logic [WORD_W-1:0] shadow;
  logic              req_p1;
  logic              stop_pending;
  logic              phase_known;
  logic              expect_fa;
  logic [3:0]        vld_cnt;

  logic bit_mid;
  logic bit_end;
  logic word_end;
  logic capture;
  logic marker_ok;
  logic to_idle;

  // Half of the sck period in clk cycles; DSD256 is the fastest we support.
  function automatic logic [2:0] rate_to_half(input logic [1:0] r);
    case (r)
      2'b00:   return 3'd4;
      2'b01:   return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= 4'(LOCK_CNT)) return 4'(LOCK_CNT);
    else                   return v + 4'd1;
  endfunction

  always_comb begin
    shifted = '0;
    sd_out  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      shifted[DATA_W*k +: DATA_W] = {shreg[DATA_W*k +: DATA_W-1], 1'b0};
      sd_out[k]                   = shreg[DATA_W*k + DATA_W-1];
    end
  end

  always_comb begin
    bit_mid  = (ph == d_half - 3'd1);
    bit_end  = (ph == d_half + d_half - 3'd1);
    word_end = bit_end && (bit_cnt == 4'd0);
    capture  = req_p1 && ((state == ST_PRIME) || (state == ST_RUN));
    to_idle  = (state == ST_SILENCE) && word_end;
    if (phase_known)
      marker_ok = (marker_in == (expect_fa ? MARK_B : MARK_A));
    else
      marker_ok = (marker_in == MARK_A) || (marker_in == MARK_B);
  end

  // Sequencing, bit clock and shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      prime_cnt    <= 2'd0;
      d_half       <= 3'd4;
      ph           <= 3'd0;
      bit_cnt      <= 4'd15;
      shreg        <= '0;
      sck_out      <= 1'b0;
      data_req_out <= 1'b0;
      req_p1       <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      data_req_out <= 1'b0;
      req_p1       <= data_req_out;
      case (state)
        ST_IDLE: begin
          d_half       <= rate_to_half(rate_sel);
          sck_out      <= 1'b0;
          shreg        <= '0;
          ph           <= 3'd0;
          bit_cnt      <= 4'd15;
          stop_pending <= 1'b0;
          prime_cnt    <= 2'd0;
          if (!start_n && stop_n) begin
            state        <= ST_PRIME;
            data_req_out <= 1'b1;
          end
        end
        ST_PRIME: begin
          prime_cnt <= prime_cnt + 2'd1;
          if (!stop_n) stop_pending <= 1'b1;
          if (prime_cnt == 2'd2) begin
            state        <= ST_RUN;
            shreg        <= shadow;
            data_req_out <= 1'b1;
            bit_cnt      <= 4'd15;
            ph           <= 3'd0;
            sck_out      <= 1'b0;
          end
        end
        default: begin
          if ((state == ST_RUN) && !stop_n) stop_pending <= 1'b1;
          if (bit_end) begin
            sck_out <= 1'b0;
            ph      <= 3'd0;
            if (bit_cnt == 4'd0) begin
              bit_cnt <= 4'd15;
              if (state == ST_SILENCE) begin
                state <= ST_IDLE;
                shreg <= '0;
              end else if (stop_pending || !stop_n) begin
                // Stop: one silence word goes out in place of the captured word.
                state <= ST_SILENCE;
                shreg <= SILENCE_WORD;
              end else begin
                shreg        <= shadow;
                data_req_out <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
              shreg   <= shifted;
            end
          end else begin
            ph <= ph + 3'd1;
            if (bit_mid) sck_out <= 1'b1;
          end
        end
      endcase
    end
  end

  // Marker validation and lock tracking, evaluated at the capture edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_known    <= 1'b0;
      expect_fa      <= 1'b0;
      vld_cnt        <= 4'd0;
      dop_lock_out   <= 1'b0;
      marker_err_out <= 1'b0;
    end else begin
      marker_err_out <= 1'b0;
      if ((state == ST_IDLE) || to_idle) begin
        phase_known  <= 1'b0;
        expect_fa    <= 1'b0;
        vld_cnt      <= 4'd0;
        dop_lock_out <= 1'b0;
      end else if (capture && (DOP_CHECK != 0)) begin
        if (marker_ok) begin
          vld_cnt      <= sat_inc(vld_cnt);
          dop_lock_out <= (sat_inc(vld_cnt) == 4'(LOCK_CNT));
        end else begin
          vld_cnt        <= 4'd0;
          dop_lock_out   <= 1'b0;
          marker_err_out <= 1'b1;
        end
        if (phase_known)
          expect_fa <= ~expect_fa;
        else if (marker_ok) begin
          phase_known <= 1'b1;
          expect_fa   <= (marker_in == MARK_A);
        end
      end
    end
  end

  // Shadow word: rejected words are replaced by DSD silence
  always_ff @(posedge clk) begin
    if (capture) begin
      if ((DOP_CHECK == 0) || marker_ok) shadow <= data_in;
      else                               shadow <= SILENCE_WORD;
    end
  end

endmodule

// File: tb/tb_dsd_master_mc.sv
// Scoreboard bench for dsd_master_mc: a 4-channel checked instance and a
// 2-channel unchecked instance share stimulus; words are rebuilt from sck rises.
module tb_dsd_master_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_n = 1'b1;
  logic        stop_n = 1'b1;
  logic [1:0]  rate_sel = 2'b00;
  logic [63:0] data_in = '0;
  logic [7:0]  marker_in = '0;

  logic       req_a, sck_a, lock_a, err_a;
  logic [3:0] sd_a;
  logic       req_b, sck_b, lock_b, err_b;
  logic [1:0] sd_b;

  localparam logic [63:0] SIL = {4{16'h6969}};

  dsd_master_mc #(.CHANNELS(4), .LOCK_CNT(4), .DOP_CHECK(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start_n(start_n), .stop_n(stop_n),
    .rate_sel(rate_sel), .data_in(data_in), .marker_in(marker_in),
    .data_req_out(req_a), .sd_out(sd_a), .sck_out(sck_a),
    .dop_lock_out(lock_a), .marker_err_out(err_a));

  dsd_master_mc #(.CHANNELS(2), .LOCK_CNT(4), .DOP_CHECK(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start_n(start_n), .stop_n(stop_n),
    .rate_sel(rate_sel), .data_in(data_in[31:0]), .marker_in(marker_in),
    .data_req_out(req_b), .sd_out(sd_b), .sck_out(sck_b),
    .dop_lock_out(lock_b), .marker_err_out(err_b));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cur_d = 8;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, want);
    end
  endtask

  // Reference model: a word is valid when its marker continues the 05/FA
  // alternation; lock means the last 4 captures were all valid.
  bit m_known;
  bit m_next_fa;
  int m_run;

  task automatic model_reset();
    m_known = 0; m_next_fa = 0; m_run = 0;
  endtask

  task automatic model_capture(input logic [7:0] m, output bit ok, output bit lk);
    if (!m_known) begin
      ok = (m == 8'h05) || (m == 8'hFA);
      if (ok) begin m_known = 1; m_next_fa = (m == 8'h05); end
    end else begin
      ok = (m == (m_next_fa ? 8'hFA : 8'h05));
      m_next_fa = !m_next_fa;
    end
    m_run = ok ? m_run + 1 : 0;
    lk = (m_run >= 4);
  endtask

  logic [63:0] q_a[$];
  logic [63:0] q_b[$];
  logic [71:0] force_q[$];

  // Source: answers each request, pushes expectations, checks err/lock timing
  bit src_phase;
  int src_nreq, src_last;
  bit no_req;
  int pend;
  bit clr;
  bit pe_err, pe_lock;

  always @(negedge clk) begin : source
    logic [71:0] f;
    logic [63:0] w;
    logic [7:0]  m;
    bit ok, lk, forced;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        check("marker_err", 64'(err_a), 64'(pe_err));
        check("dop_lock", 64'(lock_a), 64'(pe_lock));
        check("nocheck_err", 64'(err_b), 64'd0);
        check("nocheck_lock", 64'(lock_b), 64'd0);
        clr = 1;
      end
    end else if (clr) begin
      check("marker_err_pulse_end", 64'(err_a), 64'd0);
      clr = 0;
    end
    if (rst_n && req_a) begin
      if (no_req) begin
        check("req_in_silence", 64'(req_a), 64'd0);
      end else begin
        if (src_nreq > 0)
          check("req_interval", 64'(cyc - src_last), 64'((src_nreq == 1) ? 3 : 16 * cur_d));
        src_last = cyc;
        src_nreq++;
        forced = (force_q.size() > 0);
        if (forced) begin
          f = force_q.pop_front();
          w = f[63:0];
          m = f[71:64];
        end else begin
          w = {$urandom, $urandom};
          m = src_phase ? 8'hFA : 8'h05;
          if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
              0:       m = 8'h33;
              1:       m = 8'h00;
              default: m = src_phase ? 8'h05 : 8'hFA;
            endcase
          end
        end
        if (forced && ((m == 8'h05) || (m == 8'hFA))) src_phase = (m == 8'h05);
        else src_phase = !src_phase;
        data_in   = w;
        marker_in = m;
        model_capture(m, ok, lk);
        q_a.push_back(ok ? w : SIL);
        q_b.push_back({32'h0, w[31:0]});
        pe_err  = !ok;
        pe_lock = lk;
        pend    = 2;
      end
    end
  end

  // Monitor: rebuilds words from sd sampled at sck rises, pops and compares
  logic        prev_sck[2];
  int          bidx[2];
  int          lrise[2];
  logic [63:0] acc[2];

  task automatic mon_step(input int id, input logic s, input logic [3:0] d, input int nch);
    logic [63:0] want, mask;
    if (!rst_n) begin
      bidx[id] = 0;
      prev_sck[id] = 1'b0;
      return;
    end
    if (s && !prev_sck[id]) begin
      if (bidx[id] > 0)
        check($sformatf("sck_period_%0d", id), 64'(cyc - lrise[id]), 64'(cur_d));
      lrise[id] = cyc;
      for (int c = 0; c < nch; c++) acc[id][16*c + 15 - bidx[id]] = d[c];
      bidx[id]++;
      if (bidx[id] == 16) begin
        bidx[id] = 0;
        mask = (nch == 4) ? '1 : 64'h0000_0000_FFFF_FFFF;
        if ((id == 0) ? (q_a.size() == 0) : (q_b.size() == 0)) begin
          checks++;
          failures++;
          $display("FAIL word_%0d unexpected word actual=%h required=none", id, acc[id] & mask);
        end else begin
          want = (id == 0) ? q_a.pop_front() : q_b.pop_front();
          check($sformatf("word_%0d", id), acc[id] & mask, want & mask);
        end
      end
    end
    prev_sck[id] = s;
  endtask

  always @(negedge clk) begin : monitor
    mon_step(0, sck_a, sd_a, 4);
    mon_step(1, sck_b, {2'b00, sd_b}, 2);
  end

  task automatic wait_reqs(input int n);
    int seen = 0;
    for (int i = 0; (i < n * 16 * cur_d + 64) && (seen < n); i++) begin
      @(negedge clk);
      if (req_a) seen++;
    end
    check("req_count", 64'(seen), 64'(n));
  endtask

  task automatic startup(input logic [1:0] r, input logic [63:0] w, input logic [7:0] m);
    @(negedge clk);
    rate_sel = r;
    cur_d = (r == 2'b00) ? 8 : (r == 2'b01) ? 4 : 2;
    force_q.push_back({m, w});
    src_nreq = 0;
    no_req = 0;
    model_reset();
    @(negedge clk);
    start_n = 1'b0;
    stop_n  = 1'b1;
    @(negedge clk);
    check("e0_req", 64'(req_a), 64'd1);
    check("e0_req_b", 64'(req_b), 64'd1);
    @(negedge clk);
    check("e1_req", 64'(req_a), 64'd0);
    @(negedge clk);
    check("e2_req", 64'(req_a), 64'd0);
    @(negedge clk);
    check("e3_req", 64'(req_a), 64'd1);
    check("e3_sck", 64'(sck_a), 64'd0);
    check("e3_sd", 64'(sd_a), 64'({w[63], w[47], w[31], w[15]}));
    check("e3_sd_b", 64'(sd_b), 64'({w[31], w[15]}));
    for (int i = 1; i <= cur_d / 2; i++) begin
      @(negedge clk);
      check($sformatf("first_sck_%0d", i), 64'(sck_a), 64'(i == cur_d / 2));
    end
  endtask

  task automatic do_stop();
    for (int i = 0; i < 16 * cur_d + 8; i++) begin
      @(negedge clk);
      if (req_a) break;
    end
    repeat (8 * cur_d) @(negedge clk);
    stop_n  = 1'b0;
    start_n = 1'b1;
    no_req  = 1;
    if (q_a.size() > 0) q_a[q_a.size() - 1] = SIL;
    if (q_b.size() > 0) q_b[q_b.size() - 1] = {32'h0, SIL[31:0]};
    for (int i = 0; (i < 64 * cur_d) && (q_a.size() != 0); i++) @(negedge clk);
    check("stop_drain", 64'(q_a.size()), 64'd0);
    repeat (cur_d + 2) @(negedge clk);
    check("idle_sck", 64'(sck_a), 64'd0);
    check("idle_sd", 64'(sd_a), 64'd0);
    check("idle_lock", 64'(lock_a), 64'd0);
    check("idle_sck_b", 64'(sck_b), 64'd0);
    check("idle_sd_b", 64'(sd_b), 64'd0);
    stop_n = 1'b1;
    model_reset();
  endtask

  task automatic start_stop_idle();
    int seen = 0;
    @(negedge clk);
    start_n = 1'b0;
    stop_n  = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (req_a || sck_a) seen++;
    end
    check("start_stop_idle", 64'(seen), 64'd0);
    start_n = 1'b1;
    stop_n  = 1'b1;
  endtask

  task automatic reset_mid_run();
    for (int i = 0; i < 16 * cur_d + 8; i++) begin
      @(negedge clk);
      if (req_a) break;
    end
    repeat (5 * cur_d) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sd", 64'(sd_a), 64'd0);
    check("arst_sck", 64'(sck_a), 64'd0);
    check("arst_req", 64'(req_a), 64'd0);
    check("arst_lock", 64'(lock_a), 64'd0);
    check("arst_err", 64'(err_a), 64'd0);
    check("arst_sd_b", 64'(sd_b), 64'd0);
    start_n = 1'b1;
    q_a.delete();
    q_b.delete();
    bidx[0] = 0;
    bidx[1] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bidx[0] = 0; bidx[1] = 0;
    prev_sck[0] = 0; prev_sck[1] = 0;
    pend = 0; clr = 0; no_req = 0; src_phase = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_sd", 64'(sd_a), 64'd0);
    check("rst_sck", 64'(sck_a), 64'd0);
    check("rst_req", 64'(req_a), 64'd0);
    check("rst_lock", 64'(lock_a), 64'd0);
    check("rst_err", 64'(err_a), 64'd0);
    check("rst_sd_b", 64'(sd_b), 64'd0);
    rst_n = 1'b1;

    // DSD64 startup with the reference word
    startup(2'b00, {16'h1357, 16'h2468, 16'h0FF0, 16'hA5C3}, 8'h05);
    wait_reqs(8);
    do_stop();

    // DSD128; rate change while running must not take effect
    startup(2'b01, {$urandom, $urandom}, 8'h05);
    wait_reqs(4);
    rate_sel = 2'b10;
    wait_reqs(4);
    do_stop();

    // DSD256 with an injected bad marker, then stop and start/stop collision
    startup(2'b10, {$urandom, $urandom}, 8'hFA);
    wait_reqs(6);
    force_q.push_back({8'h33, $urandom, $urandom});
    wait_reqs(8);
    do_stop();
    start_stop_idle();

    // Asynchronous reset in RUN, then a clean restart
    startup(2'b00, {$urandom, $urandom}, 8'h05);
    wait_reqs(5);
    reset_mid_run();
    startup(2'b10, {$urandom, $urandom}, 8'h05);
    wait_reqs(4);
    do_stop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not complete checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
